// File: rtl/ov2640_capture_pkg.sv
// Shared constants for the OV2640 capture path, frame buffer and VGA reader:
// FSM state encoding, default frame geometry and RGB565 field positions.
package ov2640_capture_pkg;

    localparam int H_ACTIVE_DEF   = 320;
    localparam int V_ACTIVE_DEF   = 240;
    localparam int NUM_PIXELS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;
    localparam int ADDR_W_DEF     = 17;

    // RGB565 field positions inside a 16-bit pixel word
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_t;

    // The camera sends the RGB565 high byte first; the pixel word is {first, second}.
    function automatic logic [15:0] rgb565_pair(input logic [7:0] hi_byte,
                                                input logic [7:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/ov2640_capture_if.sv
// Camera DVP inputs, frame-buffer write port and tracker status of the capture block.
// The slave modport is the capture block; the master modport is whatever drives the
// camera side and consumes the write port / status.
import ov2640_capture_pkg::*;

interface ov2640_capture_if #(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              i_capture_en;
    logic              i_vsync;
    logic              i_href;
    logic [7:0]        i_cam_data;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [15:0]       o_wr_data;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_frame_err;

    modport slave (
        input  i_capture_en, i_vsync, i_href, i_cam_data,
        output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_frame_err
    );

    modport master (
        output i_capture_en, i_vsync, i_href, i_cam_data,
        input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_frame_err
    );

endinterface

// File: rtl/ov2640_byte_pair.sv
// Pairs consecutive href-qualified camera bytes into RGB565 pixels.
// Inputs are the already-registered camera signals. The pixel strobe is combinational
// so the parent can register it straight into the write port.
import ov2640_capture_pkg::*;

module ov2640_byte_pair (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,     // capture active
    input  logic        i_clear,      // start of a captured frame
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic        o_pix_valid,  // second byte of a pair present this cycle
    output logic [15:0] o_pix_data,
    output logic        o_odd_drop,   // href fell with a dangling high byte
    output logic        o_burst_end   // href fell while capturing
);

    logic       r_phase;
    logic [7:0] r_hi;
    logic       r_href_d;

    // Byte phase, high-byte latch and href history for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase  <= 1'b0;
            r_hi     <= 8'h00;
            r_href_d <= 1'b0;
        end else begin
            r_href_d <= i_href;
            if (i_clear || !i_enable) begin
                r_phase <= 1'b0;
            end else if (i_href) begin
                r_phase <= ~r_phase;
            end else begin
                // a dangling odd byte is dropped when the burst ends
                r_phase <= 1'b0;
            end
            if (i_enable && i_href && !r_phase) begin
                r_hi <= i_data;
            end else begin
                r_hi <= r_hi;
            end
        end
    end

    // Pixel strobe and burst-end events for the current registered byte
    always_comb begin
        o_pix_valid = i_enable && i_href && r_phase;
        o_pix_data  = rgb565_pair(r_hi, i_data);
        o_burst_end = i_enable && r_href_d && !i_href;
        o_odd_drop  = o_burst_end && r_phase;
    end

endmodule

// File: rtl/ov2640_capture.sv
// OV2640 DVP capture: registers the camera bus, waits for a whole frame, pairs bytes
// into RGB565 pixels and writes them to the frame buffer. Reports per-frame completion
// and whether the frame had the expected geometry.
import ov2640_capture_pkg::*;

module ov2640_capture #(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic              i_wr_clk,
    input  logic              i_rst,
    ov2640_capture_if.slave   cam
);

    localparam logic [ADDR_W-1:0] NUM_PIX_L = ADDR_W'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0] H_L       = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_L       = ADDR_W'(V_ACTIVE);

    // registered camera inputs
    logic        r_vsync;
    logic        r_vsync_d;
    logic        r_href;
    logic [7:0]  r_data;

    cap_state_t  r_state;
    cap_state_t  w_state_nxt;

    logic        w_vs_blank;
    logic        w_vs_rise;
    logic        w_vs_fall;
    logic        w_active;
    logic        w_enter_active;
    logic        w_frame_end;

    logic        w_pix_valid;
    logic [15:0] w_pix_data;
    logic        w_odd_drop;
    logic        w_burst_end;

    logic [ADDR_W-1:0] r_pix_idx;
    logic [ADDR_W-1:0] r_line_pix;
    logic [ADDR_W-1:0] r_line_cnt;
    logic              r_line_err;
    logic              r_ovf_err;

    logic              w_pix_fire;
    logic              w_pix_ovf;
    logic              w_line_close;
    logic              w_line_bad;
    logic              w_line_err_nxt;
    logic              w_ovf_nxt;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [ADDR_W-1:0] w_lines_nxt;
    logic              w_frame_err;

    // Single register stage on every camera input; vsync history for edge detection
    always_ff @(posedge i_wr_clk or posedge i_rst) begin
        if (i_rst) begin
            // idle at the active-video level so no false edge follows reset
            r_vsync   <= ~VSYNC_POL;
            r_vsync_d <= ~VSYNC_POL;
            r_href    <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_vsync   <= cam.i_vsync;
            r_vsync_d <= r_vsync;
            r_href    <= cam.i_href;
            r_data    <= cam.i_cam_data;
        end
    end

    // vsync level and edges seen on the registered copy
    always_comb begin
        w_vs_blank = (r_vsync == VSYNC_POL);
        w_vs_rise  = (r_vsync == VSYNC_POL) && (r_vsync_d != VSYNC_POL);
        w_vs_fall  = (r_vsync != VSYNC_POL) && (r_vsync_d == VSYNC_POL);
    end

    // FSM state register; busy is registered alongside it so it equals state==ACTIVE
    always_ff @(posedge i_wr_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_SYNC;
            cam.o_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            cam.o_busy <= (w_state_nxt == ST_ACTIVE);
        end
    end

    // FSM next state: SYNC skips the frame in progress, VBLANK decides per frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC: begin
                if (w_vs_blank) begin
                    w_state_nxt = ST_VBLANK;
                end else begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_VBLANK: begin
                if (w_vs_fall && cam.i_capture_en) begin
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_VBLANK;
                end
            end
            ST_ACTIVE: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_VBLANK;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // FSM outputs: capture window, frame start and frame end events
    always_comb begin
        w_active       = 1'b0;
        w_enter_active = 1'b0;
        w_frame_end    = 1'b0;
        case (r_state)
            ST_VBLANK: begin
                w_enter_active = w_vs_fall && cam.i_capture_en;
            end
            ST_ACTIVE: begin
                w_active    = 1'b1;
                w_frame_end = w_vs_rise;
            end
            default: begin
                w_active = 1'b0;
            end
        endcase
    end

    ov2640_byte_pair u_byte_pair (
        .i_clk       (i_wr_clk),
        .i_rst       (i_rst),
        .i_enable    (w_active),
        .i_clear     (w_enter_active),
        .i_href      (r_href),
        .i_data      (r_data),
        .o_pix_valid (w_pix_valid),
        .o_pix_data  (w_pix_data),
        .o_odd_drop  (w_odd_drop),
        .o_burst_end (w_burst_end)
    );

    // Next values of the frame counters and error flags, including this cycle's events
    always_comb begin
        w_pix_fire     = w_pix_valid && (r_pix_idx != NUM_PIX_L);
        w_pix_ovf      = w_pix_valid && (r_pix_idx == NUM_PIX_L);
        // a line closes on href fall, or when vsync cuts it short
        w_line_close   = w_burst_end || (w_frame_end && r_href);
        w_line_bad     = w_odd_drop || (r_line_pix != H_L) || (w_frame_end && r_href);
        w_line_err_nxt = r_line_err || (w_line_close && w_line_bad);
        w_ovf_nxt      = r_ovf_err || w_pix_ovf;
        w_idx_nxt      = r_pix_idx + ADDR_W'(w_pix_fire);
        w_lines_nxt    = r_line_cnt + ADDR_W'(w_line_close);
        w_frame_err    = w_line_err_nxt || w_ovf_nxt ||
                         (w_idx_nxt != NUM_PIX_L) || (w_lines_nxt != V_L);
    end

    // Frame counters and sticky error flags, cleared at the start of each captured frame
    always_ff @(posedge i_wr_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix_idx  <= '0;
            r_line_pix <= '0;
            r_line_cnt <= '0;
            r_line_err <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else if (w_enter_active) begin
            r_pix_idx  <= '0;
            r_line_pix <= '0;
            r_line_cnt <= '0;
            r_line_err <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else if (w_active) begin
            r_pix_idx  <= w_idx_nxt;
            r_line_cnt <= w_lines_nxt;
            r_line_err <= w_line_err_nxt;
            r_ovf_err  <= w_ovf_nxt;
            if (w_line_close) begin
                r_line_pix <= '0;
            end else begin
                r_line_pix <= r_line_pix + ADDR_W'(w_pix_valid);
            end
        end else begin
            r_pix_idx  <= r_pix_idx;
            r_line_pix <= r_line_pix;
            r_line_cnt <= r_line_cnt;
            r_line_err <= r_line_err;
            r_ovf_err  <= r_ovf_err;
        end
    end

    // Registered frame-buffer write port
    always_ff @(posedge i_wr_clk or posedge i_rst) begin
        if (i_rst) begin
            cam.o_wr_en   <= 1'b0;
            cam.o_wr_addr <= '0;
            cam.o_wr_data <= 16'h0000;
        end else begin
            cam.o_wr_en <= w_pix_fire;
            if (w_pix_fire) begin
                cam.o_wr_addr <= r_pix_idx;
                cam.o_wr_data <= w_pix_data;
            end else if (w_enter_active) begin
                cam.o_wr_addr <= '0;
            end else begin
                cam.o_wr_addr <= cam.o_wr_addr;
            end
        end
    end

    // Registered per-frame status, raised the cycle after the frame ends
    always_ff @(posedge i_wr_clk or posedge i_rst) begin
        if (i_rst) begin
            cam.o_frame_done <= 1'b0;
            cam.o_frame_err  <= 1'b0;
        end else begin
            cam.o_frame_done <= w_frame_end;
            cam.o_frame_err  <= w_frame_end && w_frame_err;
        end
    end

endmodule

// File: tb/tb_ov2640_capture.sv
// Scoreboard bench for ov2640_capture on a reduced frame geometry. The frame driver
// computes every expected write and frame status from the frame's byte pattern and
// queues it; an independent monitor compares whatever the DUT emits.
import ov2640_capture_pkg::*;

module tb_ov2640_capture;

    localparam int H    = 8;
    localparam int V    = 6;
    localparam int NPIX = H * V;
    localparam int AW   = 6;

    typedef struct {
        int addr;
        int data;
        int drv;   // cycle on which the second byte was put on the pins
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    wr_t  wq[$];
    bit   fq[$];
    wr_t  mon_e;
    bit   mon_f;
    int   checks = 0;
    int   errors = 0;
    bit   synced = 1'b0;

    ov2640_capture_if #(.ADDR_W(AW)) cam ();

    ov2640_capture #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .NUM_PIXELS (NPIX),
        .ADDR_W     (AW),
        .VSYNC_POL  (1'b1)
    ) dut (
        .i_wr_clk (clk),
        .i_rst    (rst),
        .cam      (cam)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every DUT output event against the queued expectations
    always @(negedge clk) begin
        if (cam.o_wr_en) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h", cam.o_wr_addr, cam.o_wr_data);
            end else begin
                mon_e = wq.pop_front();
                if (int'(cam.o_wr_addr) != mon_e.addr || int'(cam.o_wr_data) != mon_e.data) begin
                    errors++;
                    $display("FAIL write_data actual addr=%0d data=%h required addr=%0d data=%h",
                             cam.o_wr_addr, cam.o_wr_data, mon_e.addr, mon_e.data[15:0]);
                end
                checks++;
                if (cyc - mon_e.drv != 2) begin
                    errors++;
                    $display("FAIL write_latency actual=%0d required=2", cyc - mon_e.drv);
                end
            end
        end
        if (cam.o_frame_done) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done err=%0b", cam.o_frame_err);
            end else begin
                mon_f = fq.pop_front();
                if (cam.o_frame_err != mon_f) begin
                    errors++;
                    $display("FAIL frame_err actual=%0b required=%0b", cam.o_frame_err, mon_f);
                end
            end
        end else if (cam.o_frame_err) begin
            checks++;
            errors++;
            $display("FAIL frame_err_without_done actual=1 required=0");
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_en", int'(cam.o_wr_en), 0);
        check("rst_wr_addr", int'(cam.o_wr_addr), 0);
        check("rst_wr_data", int'(cam.o_wr_data), 0);
        check("rst_busy", int'(cam.o_busy), 0);
        check("rst_frame_done", int'(cam.o_frame_done), 0);
        check("rst_frame_err", int'(cam.o_frame_err), 0);
    endtask

    // One camera frame: vsync pulse, then nlines href bursts. A line normally carries
    // 2*H bytes; odd_line gets one extra byte, short_line two fewer. rst_line pulses
    // reset at the start of that line.
    task automatic run_frame(input int nlines, input int odd_line, input int short_line,
                             input bit cap_start, input bit raise_mid, input int rst_line,
                             input bit fixed_first);
        int         idx;
        int         nbytes;
        bit         err;
        bit         cap;
        logic [7:0] hi;
        logic [7:0] b;
        idx = 0;
        err = 1'b0;
        hi  = 8'h00;
        cam.i_vsync      = 1'b1;
        cam.i_capture_en = cap_start;
        synced           = 1'b1;
        tick(4);
        cap = synced && cap_start;
        cam.i_vsync = 1'b0;
        tick(4);
        check("busy_frame_start", int'(cam.o_busy), int'(cap));
        for (int l = 0; l < nlines; l++) begin
            if (l == rst_line) begin
                rst = 1'b1;
                #1;
                check_reset_outputs();
                tick(3);
                rst    = 1'b0;
                synced = 1'b0;
                cap    = 1'b0;
            end
            if (raise_mid && l == nlines / 2) cam.i_capture_en = 1'b1;
            nbytes = 2 * H + ((l == odd_line) ? 1 : 0) - ((l == short_line) ? 2 : 0);
            cam.i_href = 1'b1;
            for (int j = 0; j < nbytes; j++) begin
                b = 8'($urandom);
                if (fixed_first && l == 0 && j == 0) b = 8'hF8;
                if (fixed_first && l == 0 && j == 1) b = 8'h1F;
                cam.i_cam_data = b;
                if (j % 2 == 0) begin
                    hi = b;
                end else if (cap) begin
                    if (idx < NPIX) wq.push_back('{addr: idx, data: int'({hi, b}), drv: cyc});
                    else err = 1'b1;
                    idx++;
                end
                tick(1);
            end
            cam.i_href     = 1'b0;
            cam.i_cam_data = 8'($urandom);
            if (nbytes != 2 * H) err = 1'b1;
            tick(4);
        end
        tick(3);
        check("busy_frame_end", int'(cam.o_busy), int'(cap));
        if (cap) begin
            if (idx != NPIX) err = 1'b1;
            if (nlines != V) err = 1'b1;
            fq.push_back(err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        cam.i_capture_en = 1'b0;
        cam.i_vsync      = 1'b0;
        cam.i_href       = 1'b0;
        cam.i_cam_data   = 8'h00;
        tick(3);
        check_reset_outputs();
        rst = 1'b0;
        tick(2);

        // full frame with a known first pixel, then another clean frame
        run_frame(V, -1, -1, 1'b1, 1'b0, -1, 1'b1);
        run_frame(V, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        // skipped frame with capture_en raised mid-frame, then a captured one
        run_frame(V, -1, -1, 1'b0, 1'b1, -1, 1'b0);
        run_frame(V, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        // reset in the middle of a captured frame, then recovery
        run_frame(V, -1, -1, 1'b1, 1'b0, 3, 1'b0);
        run_frame(V, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        run_frame(V, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        // one line with an extra byte, then a clean frame
        run_frame(V, 2, -1, 1'b1, 1'b0, -1, 1'b0);
        run_frame(V, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        // one line too many: overflow, then a clean frame
        run_frame(V + 1, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        run_frame(V, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        // short line and short frame
        run_frame(V, -1, 4, 1'b1, 1'b0, -1, 1'b0);
        run_frame(V - 1, -1, -1, 1'b1, 1'b0, -1, 1'b0);
        // randomized frames
        for (int f = 0; f < 8; f++) begin
            run_frame(V - 1 + int'($urandom_range(0, 2)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V - 1)) : -1,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V - 1)) : -1,
                      1'($urandom_range(0, 1)), 1'b0, -1, 1'b0);
        end

        // closing vsync ends the last frame
        cam.i_vsync = 1'b1;
        tick(10);
        check("pending_writes", wq.size(), 0);
        check("pending_frames", fq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
